// File: rtl/clb_lvds_rx.sv
// Camera Link 7:1 receiver: frame alignment on the clock lane and decoding of the X0..X3 data lanes.
// Define CLB_LVDS_RX_ERR_CNT_EN to build the saturating alignment-error counter behind err_cnt.
//
// state  | meaning
// HUNT   | searching every cycle for the 1100011 clock-lane marker
// CHECK  | marker found, confirming it on following frame boundaries
// LOCKED | aligned; capturing one word per frame, tolerating a single miss

module clb_lvds_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        lvds_clk,
    input  logic        d0,
    input  logic        d1,
    input  logic        d2,
    input  logic        d3,
    output logic        locked,
    output logic        pix_valid,
    output logic [27:0] raw,
    output logic [7:0]  port_a,
    output logic [7:0]  port_b,
    output logic [7:0]  port_c,
    output logic        lval,
    output logic        fval,
    output logic        dval,
    output logic        spare,
    output logic        lock_lost,
    output logic [15:0] err_cnt
);

    localparam logic [6:0] MARKER = 7'b1100011;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  sr_clk, sr_d0, sr_d1, sr_d2, sr_d3;
    logic [2:0]  bit_cnt;
    logic [2:0]  match_cnt;
    logic        miss_cnt;
    logic        marker;
    logic        eval;
    logic        bit_clr;
    logic        match_inc;
    logic        capture;
    logic        mis_eval;
    logic        lost;
    logic [27:0] word_nxt;

    // First-received bit sits in sr[6] but belongs at word bit 0.
    function automatic logic [6:0] rev7(input logic [6:0] v);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = v[6-i];
        return r;
    endfunction

    assign marker   = (sr_clk == MARKER);
    assign eval     = (bit_cnt == 3'd6);
    assign word_nxt = {rev7(sr_d3), rev7(sr_d2), rev7(sr_d1), rev7(sr_d0)};
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_clk <= '0;
            sr_d0  <= '0;
            sr_d1  <= '0;
            sr_d2  <= '0;
            sr_d3  <= '0;
        end else begin
            sr_clk <= {sr_clk[5:0], lvds_clk};
            sr_d0  <= {sr_d0[5:0], d0};
            sr_d1  <= {sr_d1[5:0], d1};
            sr_d2  <= {sr_d2[5:0], d2};
            sr_d3  <= {sr_d3[5:0], d3};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bit_clr   = 1'b0;
        match_inc = 1'b0;
        capture   = 1'b0;
        mis_eval  = 1'b0;
        lost      = 1'b0;
        case (state)
            HUNT: begin
                if (marker) begin
                    state_nxt = CHECK;
                    bit_clr   = 1'b1;
                end
            end
            CHECK: begin
                if (eval) begin
                    if (marker) begin
                        match_inc = 1'b1;
                        if (match_cnt == 3'd3) state_nxt = LOCKED;
                    end else begin
                        mis_eval  = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (eval) begin
                    if (marker) begin
                        capture = 1'b1;
                    end else begin
                        mis_eval = 1'b1;
                        if (miss_cnt) begin
                            state_nxt = HUNT;
                            lost      = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            match_cnt <= '0;
            miss_cnt  <= 1'b0;
        end else begin
            if (bit_clr || eval) bit_cnt <= '0;
            else                 bit_cnt <= bit_cnt + 3'd1;

            if (state == HUNT)           match_cnt <= marker ? 3'd1 : 3'd0;
            else if (state_nxt == HUNT)  match_cnt <= '0;
            else if (match_inc)          match_cnt <= match_cnt + 3'd1;

            if (state_nxt == HUNT || capture)    miss_cnt <= 1'b0;
            else if (mis_eval && state == LOCKED) miss_cnt <= 1'b1;
        end
    end

    // Data outputs only move on a captured frame; HUNT entry leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw       <= '0;
            pix_valid <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            pix_valid <= capture;
            lock_lost <= lost;
            if (capture) raw <= word_nxt;
        end
    end

    assign port_a = {raw[22], raw[21], raw[5:0]};
    assign port_b = {raw[24], raw[23], raw[11:7], raw[6]};
    assign port_c = {raw[26], raw[25], raw[17:14], raw[13:12]};
    assign lval   = raw[18];
    assign fval   = raw[19];
    assign dval   = raw[20];
    assign spare  = raw[27];

`ifdef CLB_LVDS_RX_ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               err_q <= '0;
        else if (mis_eval && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_clb_lvds_rx.sv
// Directed bench for clb_lvds_rx: lock acquisition, decode, single/double miss, CHECK abort, mid-word reset.
module tb_clb_lvds_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        lvds_clk, d0, d1, d2, d3;
    logic        locked, pix_valid, lock_lost;
    logic [27:0] raw;
    logic [7:0]  port_a, port_b, port_c;
    logic        lval, fval, dval, spare;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    int   f_pv_cnt, f_lost_cnt;
    logic f_pv_first, f_locked_first, f_locked_any;

    localparam logic [6:0]  MK  = 7'b1100011;
    localparam logic [6:0]  BAD = 7'b1100111;
    // Frame word w: lane k carries w[7k+i] as its i-th transmitted bit.
    // W1: A=A5 B=3C C=81 LVAL=1 FVAL=1 DVAL=0 SPARE=1
    localparam logic [27:0] W1 = 28'hC4C1F25;
    // W2: X0 all ones -> A=3F B=01
    localparam logic [27:0] W2 = 28'h000007F;
    // W3: X3 all ones -> A=C0 B=C0 C=C0 SPARE=1
    localparam logic [27:0] W3 = 28'hFE00000;

`ifdef CLB_LVDS_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    clb_lvds_rx dut (
        .clk       (clk),
        .rst       (rst),
        .lvds_clk  (lvds_clk),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .locked    (locked),
        .pix_valid (pix_valid),
        .raw       (raw),
        .port_a    (port_a),
        .port_b    (port_b),
        .port_c    (port_c),
        .lval      (lval),
        .fval      (fval),
        .dval      (dval),
        .spare     (spare),
        .lock_lost (lock_lost),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one bit per cycle and samples at the following negedge.
    task automatic send_bits(input logic [6:0] pat, input logic [27:0] w, input int nbits);
        f_pv_cnt   = 0;
        f_lost_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            lvds_clk = pat[6-i];
            d0 = w[i];
            d1 = w[7+i];
            d2 = w[14+i];
            d3 = w[21+i];
            @(posedge clk);
            @(negedge clk);
            if (pix_valid === 1'b1) f_pv_cnt++;
            if (lock_lost === 1'b1) f_lost_cnt++;
            if (locked === 1'b1)    f_locked_any = 1'b1;
            if (i == 0) begin
                f_pv_first     = pix_valid;
                f_locked_first = locked;
            end
        end
    endtask

    task automatic send_frame(input logic [6:0] pat, input logic [27:0] w);
        send_bits(pat, w, 7);
    endtask

    task automatic chk_word(input string tag, input logic [27:0] w);
        chk({tag, "_raw"},    {4'h0, raw},    {4'h0, w});
        chk({tag, "_port_a"}, {24'h0, port_a}, {24'h0, w[22], w[21], w[5:0]});
        chk({tag, "_port_b"}, {24'h0, port_b}, {24'h0, w[24], w[23], w[11:7], w[6]});
        chk({tag, "_port_c"}, {24'h0, port_c}, {24'h0, w[26], w[25], w[17:14], w[13:12]});
        chk({tag, "_flags"},  {28'h0, spare, dval, fval, lval}, {28'h0, w[27], w[20], w[19], w[18]});
    endtask

    initial begin
        rst = 1'b0;
        lvds_clk = 1'b0; d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        f_locked_any = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_locked",    {31'h0, locked},    32'h0);
        chk("rst_pix_valid", {31'h0, pix_valid}, 32'h0);
        chk("rst_lock_lost", {31'h0, lock_lost}, 32'h0);
        chk("rst_raw",       {4'h0, raw},        32'h0);
        chk("rst_err_cnt",   {16'h0, err_cnt},   32'h0);
        rst = 1'b1;

        // Acquisition: four matched frames, locked seen on the edge after the 4th.
        send_frame(MK, W1);
        send_frame(MK, W1);
        send_frame(MK, W1);
        chk("acq_f3_locked", {31'h0, locked}, 32'h0);
        send_frame(MK, W1);
        chk("acq_f4_locked", {31'h0, locked}, 32'h0);
        send_frame(MK, W1);
        chk("acq_f5_locked", {31'h0, f_locked_first}, 32'h1);
        chk("acq_f5_no_pv",  f_pv_cnt, 32'd0);

        // First capture one cycle after frame 5's 7th bit.
        send_frame(MK, W2);
        chk("cap1_pv_first", {31'h0, f_pv_first}, 32'h1);
        chk("cap1_pv_cnt",   f_pv_cnt, 32'd1);
        chk("cap1_raw_hand", {4'h0, raw}, 32'h0C4C1F25);
        chk("cap1_port_a",   {24'h0, port_a}, 32'hA5);
        chk("cap1_port_b",   {24'h0, port_b}, 32'h3C);
        chk("cap1_port_c",   {24'h0, port_c}, 32'h81);
        chk("cap1_flags",    {28'h0, spare, dval, fval, lval}, 32'hB);

        send_frame(MK, W3);
        chk("cap2_pv_first", {31'h0, f_pv_first}, 32'h1);
        chk("cap2_pv_cnt",   f_pv_cnt, 32'd1);
        chk_word("cap2", W2);
        chk("cap2_port_a_hand", {24'h0, port_a}, 32'h3F);

        // One corrupted clock-lane frame while locked.
        send_frame(BAD, W1);
        chk("cap3_pv_cnt", f_pv_cnt, 32'd1);
        chk_word("cap3", W3);
        chk("cap3_port_c_hand", {24'h0, port_c}, 32'hC0);
        send_frame(MK, W2);
        chk("miss1_no_pv",  f_pv_cnt, 32'd0);
        chk("miss1_locked", {31'h0, locked}, 32'h1);
        chk("miss1_hold",   {4'h0, raw}, {4'h0, W3});
        chk("miss1_err",    {16'h0, err_cnt}, ERR_EN ? 32'd1 : 32'd0);
        send_frame(MK, W1);
        chk("after_miss_pv", f_pv_cnt, 32'd1);
        chk_word("after_miss", W2);

        // Two consecutive bad frames drop lock.
        send_frame(BAD, W2);
        chk("pre_loss_pv", f_pv_cnt, 32'd1);
        chk_word("pre_loss", W1);
        send_frame(BAD, W2);
        chk("loss_miss1_pv",     f_pv_cnt, 32'd0);
        chk("loss_miss1_locked", {31'h0, locked}, 32'h1);
        send_frame(MK, W3);
        chk("loss_lost_first",  {31'h0, f_locked_first}, 32'h0);
        chk("loss_lost_cnt",    f_lost_cnt, 32'd1);
        chk("loss_no_pv",       f_pv_cnt, 32'd0);
        chk("loss_hold_raw",    {4'h0, raw}, {4'h0, W1});
        chk("loss_err",         {16'h0, err_cnt}, ERR_EN ? 32'd3 : 32'd0);

        // Re-lock: frames 2..4 of the new acquisition, then locked.
        f_locked_any = 1'b0;
        send_frame(MK, W3);
        send_frame(MK, W3);
        send_frame(MK, W3);
        chk("relock_not_early", {31'h0, f_locked_any}, 32'h0);
        send_frame(MK, W2);
        chk("relock_locked", {31'h0, f_locked_first}, 32'h1);
        chk("relock_lost0",  f_lost_cnt, 32'd0);
        send_frame(MK, W1);
        chk("relock_pv", f_pv_cnt, 32'd1);
        chk_word("relock", W2);

        // Reset mid-word while locked.
        send_bits(MK, W3, 3);
        rst = 1'b0;
        #1;
        chk("mrst_locked", {31'h0, locked},    32'h0);
        chk("mrst_pv",     {31'h0, pix_valid}, 32'h0);
        chk("mrst_raw",    {4'h0, raw},        32'h0);
        chk("mrst_ports",  {8'h0, port_a, port_b, port_c}, 32'h0);
        chk("mrst_err",    {16'h0, err_cnt},   32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Match then mismatch in CHECK: back to HUNT, never locked.
        f_locked_any = 1'b0;
        send_frame(MK, W1);
        send_frame(BAD, W1);
        send_frame(MK, W3);
        chk("chk_abort_locked", {31'h0, f_locked_any}, 32'h0);
        chk("chk_abort_err",    {16'h0, err_cnt}, ERR_EN ? 32'd1 : 32'd0);

        send_frame(MK, W3);
        send_frame(MK, W3);
        send_frame(MK, W3);
        chk("post_rst_not_early", {31'h0, f_locked_any}, 32'h0);
        chk("post_rst_raw0",      {4'h0, raw}, 32'h0);
        send_frame(MK, W2);
        chk("post_rst_locked", {31'h0, f_locked_first}, 32'h1);
        chk("post_rst_no_pv",  f_pv_cnt, 32'd0);
        send_frame(MK, W1);
        chk("post_rst_pv", f_pv_cnt, 32'd1);
        chk_word("post_rst", W2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
